// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared constants, FSM encoding and data-word packing for the
//               keypad event queue (consumer side of the keypad link).
// Revision    : 1.0  initial release
// ============================================================================
package keypad_pkg;

  // Default configuration
  localparam int         DEPTH_DEFAULT     = 8;
  localparam logic [7:0] DATA_PORT_DEFAULT = 8'h01;
  localparam logic [7:0] STAT_PORT_DEFAULT = 8'h02;

  // data_word bit positions
  localparam int NONEMPTY_BIT = 7;
  localparam int OVF_BIT      = 6;

  // Interrupt handshake state encoding
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  // Packs the head-of-queue word. The key nibble is forced to zero when the
  // queue is empty so stale storage never leaks onto the port mux.
  function automatic logic [7:0] make_data_word(input logic       nonempty,
                                                input logic       ovf,
                                                input logic [3:0] head);
    logic [7:0] w;
    w               = 8'h00;
    w[NONEMPTY_BIT] = nonempty;
    w[OVF_BIT]      = ovf;
    w[3:0]          = nonempty ? head : 4'h0;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
// Module      : key_fifo
// Description : Synchronous DEPTH x 4-bit FIFO for keypad events.
//               A push on a full FIFO is accepted only when a pop happens in
//               the same cycle; a pop on an empty FIFO is ignored.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push, i_data  - push request and key nibble
//               i_pop           - pop request (ignored when empty)
//               o_head          - entry at the read pointer
//               o_full, o_empty - occupancy flags
//               o_count         - number of stored entries, 0..DEPTH
// Revision    : 1.0  initial release
// ============================================================================
module key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [3:0]               i_data,
  input  logic                     i_pop,
  output logic [3:0]               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [3:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic w_empty;
  logic w_full;
  logic w_do_pop;
  logic w_do_push;

  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop & ~w_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~w_full | w_do_pop);

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/keypad_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : keypad_event_queue
// Description : Synchronises the keypad_controller valid/data pair into the
//               CPU clock domain, queues one entry per key press and raises a
//               request/ack/service interrupt towards the PicoBlaze.
// Ports       : clk, rst           - CPU clock, synchronous active-high reset
//               key_valid          - async key strobe (level, >= 1 ms)
//               key_data           - key code, stable while key_valid high
//               port_id            - PicoBlaze port address
//               read_strobe        - PicoBlaze read strobe
//               interrupt_ack      - PicoBlaze interrupt acknowledge
//               data_word          - {nonempty, overflow, 2'b00, head_key}
//               stat_word          - {4'b0000, count}
//               interrupt          - registered interrupt request
//               overflow           - sticky dropped-key flag
// Revision    : 1.0  initial release
// ============================================================================
module keypad_event_queue
  import keypad_pkg::*;
#(
  parameter int         DEPTH     = DEPTH_DEFAULT,
  parameter logic [7:0] DATA_PORT = DATA_PORT_DEFAULT,
  parameter logic [7:0] STAT_PORT = STAT_PORT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_data,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] data_word,
  output logic [7:0] stat_word,
  output logic       interrupt,
  output logic       overflow
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Input synchroniser and edge detect
  logic       r_kv_s1;
  logic       r_kv_s2;
  logic       r_kv_prev;
  logic [3:0] r_kd_s1;
  logic [3:0] r_kd_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kv_s1   <= 1'b0;
      r_kv_s2   <= 1'b0;
      r_kv_prev <= 1'b0;
      r_kd_s1   <= 4'h0;
      r_kd_s2   <= 4'h0;
    end else begin
      r_kv_s1   <= key_valid;
      r_kv_s2   <= r_kv_s1;
      r_kv_prev <= r_kv_s2;
      r_kd_s1   <= key_data;
      r_kd_s2   <= r_kd_s1;
    end
  end

  logic w_push;
  assign w_push = r_kv_s2 & ~r_kv_prev;

  // Port decode. If both ports were ever configured to the same address the
  // access is treated as a status read so it can never pop by accident.
  logic w_data_rd;
  assign w_data_rd = read_strobe & (port_id == DATA_PORT) & (port_id != STAT_PORT);

  // FIFO
  logic [3:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_pop;

  assign w_pop = w_data_rd & ~w_empty;

  key_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (r_kd_s2),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky overflow; read-to-clear on any DATA_PORT read, but a drop in the
  // same cycle as the clearing read keeps it set.
  logic w_ovf_event;
  logic r_overflow;

  assign w_ovf_event = w_push & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_event) begin
      r_overflow <= 1'b1;
    end else if (w_data_rd) begin
      r_overflow <= 1'b0;
    end
  end

  // Interrupt handshake FSM
  irq_state_t r_state;
  irq_state_t w_next_state;
  logic       r_interrupt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_interrupt <= (w_next_state == REQ);
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (!w_empty)      w_next_state = REQ;
      REQ:     if (interrupt_ack) w_next_state = SERVICE;
      SERVICE: if (w_pop)         w_next_state = IDLE;
      default:                    w_next_state = IDLE;
    endcase
  end

  // Outputs
  assign data_word = make_data_word(~w_empty, r_overflow, w_head);
  assign stat_word = {4'b0000, 4'(w_count)};
  assign interrupt = r_interrupt;
  assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_event_queue
// Description : Directed self-checking bench for keypad_event_queue.
// Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_event_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_data = 4'h0;
  logic [7:0] port_id = 8'h00;
  logic       read_strobe = 1'b0;
  logic       interrupt_ack = 1'b0;
  logic [7:0] data_word;
  logic [7:0] stat_word;
  logic       interrupt;
  logic       overflow;

  int n_pass  = 0;
  int n_total = 0;

  keypad_event_queue #(
    .DEPTH     (8),
    .DATA_PORT (8'h01),
    .STAT_PORT (8'h02)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_valid     (key_valid),
    .key_data      (key_data),
    .port_id       (port_id),
    .read_strobe   (read_strobe),
    .interrupt_ack (interrupt_ack),
    .data_word     (data_word),
    .stat_word     (stat_word),
    .interrupt     (interrupt),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  // Stimulus helpers (all start and end on a falling edge)
  task automatic apply_reset();
    rst = 1'b1; key_valid = 1'b0; key_data = 4'h0;
    port_id = 8'h00; read_strobe = 1'b0; interrupt_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_key(input logic [3:0] k);
    key_data = k; key_valid = 1'b1;
    repeat (4) @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_port(input logic [7:0] p, output logic [7:0] dw);
    port_id = p; read_strobe = 1'b1;
    #1 dw = data_word;
    @(negedge clk);
    read_strobe = 1'b0; port_id = 8'h00;
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (data_word !== 8'h00) $display("FAIL reset_data_word: got %h expected %h", data_word, 8'h00); else n_pass++;
    n_total++; if (stat_word !== 8'h00) $display("FAIL reset_stat_word: got %h expected %h", stat_word, 8'h00); else n_pass++;
    n_total++; if ({interrupt, overflow} !== 2'b00) $display("FAIL reset_irq_ovf: got %b expected %b", {interrupt, overflow}, 2'b00); else n_pass++;
  endtask

  task automatic test_first_key();
    key_data = 4'h5; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (stat_word !== 8'h00) $display("FAIL latency_2_edges: got %h expected %h", stat_word, 8'h00); else n_pass++;
    @(negedge clk);
    n_total++; if (stat_word !== 8'h01) $display("FAIL latency_3_edges: got %h expected %h", stat_word, 8'h01); else n_pass++;
    n_total++; if (data_word !== 8'h85) $display("FAIL first_data_word: got %h expected %h", data_word, 8'h85); else n_pass++;
    n_total++; if (interrupt !== 1'b0) $display("FAIL irq_before_req: got %b expected %b", interrupt, 1'b0); else n_pass++;
    @(negedge clk);
    n_total++; if (interrupt !== 1'b1) $display("FAIL irq_req: got %b expected %b", interrupt, 1'b1); else n_pass++;
    repeat (2000) @(negedge clk);
    n_total++; if (stat_word !== 8'h01) $display("FAIL held_single_push: got %h expected %h", stat_word, 8'h01); else n_pass++;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ack_read();
    logic [7:0] dw;
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    n_total++; if (interrupt !== 1'b0) $display("FAIL irq_after_ack: got %b expected %b", interrupt, 1'b0); else n_pass++;
    read_port(8'h01, dw);
    n_total++; if (dw !== 8'h85) $display("FAIL pop_data_word: got %h expected %h", dw, 8'h85); else n_pass++;
    n_total++; if (stat_word !== 8'h00) $display("FAIL count_after_pop: got %h expected %h", stat_word, 8'h00); else n_pass++;
    repeat (2) @(negedge clk);
    n_total++; if (interrupt !== 1'b0) $display("FAIL irq_idle_empty: got %b expected %b", interrupt, 1'b0); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [7:0] dw;
    logic [7:0] exp_tbl [8];
    exp_tbl = '{8'hC1, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88};
    apply_reset();
    for (int k = 1; k <= 9; k++) push_key(4'(k));
    n_total++; if (stat_word !== 8'h08) $display("FAIL ovf_count: got %h expected %h", stat_word, 8'h08); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected %b", overflow, 1'b1); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      read_port(8'h01, dw);
      n_total++; if (dw !== exp_tbl[i]) $display("FAIL ovf_drain_%0d: got %h expected %h", i, dw, exp_tbl[i]); else n_pass++;
      if (i == 0) begin
        n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected %b", overflow, 1'b0); else n_pass++;
      end
    end
    n_total++; if (stat_word !== 8'h00) $display("FAIL ovf_drained: got %h expected %h", stat_word, 8'h00); else n_pass++;
  endtask

  task automatic test_back_to_back_full();
    logic [7:0] dw;
    logic [7:0] exp_tbl [8];
    exp_tbl = '{8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87, 8'h88, 8'h8A};
    apply_reset();
    for (int k = 1; k <= 8; k++) push_key(4'(k));
    key_data = 4'hA; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    read_port(8'h01, dw);
    n_total++; if (dw !== 8'h81) $display("FAIL full_pp_data: got %h expected %h", dw, 8'h81); else n_pass++;
    n_total++; if (stat_word !== 8'h08) $display("FAIL full_pp_count: got %h expected %h", stat_word, 8'h08); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL full_pp_ovf: got %b expected %b", overflow, 1'b0); else n_pass++;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      read_port(8'h01, dw);
      n_total++; if (dw !== exp_tbl[i]) $display("FAIL full_pp_order_%0d: got %h expected %h", i, dw, exp_tbl[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back_partial();
    logic [7:0] dw;
    logic [7:0] exp_tbl [3];
    exp_tbl = '{8'h82, 8'h83, 8'h84};
    apply_reset();
    for (int k = 1; k <= 3; k++) push_key(4'(k));
    key_data = 4'h4; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    read_port(8'h01, dw);
    n_total++; if (dw !== 8'h81) $display("FAIL part_pp_data: got %h expected %h", dw, 8'h81); else n_pass++;
    n_total++; if (stat_word !== 8'h03) $display("FAIL part_pp_count: got %h expected %h", stat_word, 8'h03); else n_pass++;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      read_port(8'h01, dw);
      n_total++; if (dw !== exp_tbl[i]) $display("FAIL part_pp_order_%0d: got %h expected %h", i, dw, exp_tbl[i]); else n_pass++;
    end
  endtask

  task automatic test_empty_and_status();
    logic [7:0] dw;
    apply_reset();
    read_port(8'h01, dw);
    n_total++; if (dw !== 8'h00) $display("FAIL empty_read_data: got %h expected %h", dw, 8'h00); else n_pass++;
    n_total++; if (stat_word !== 8'h00) $display("FAIL empty_read_count: got %h expected %h", stat_word, 8'h00); else n_pass++;
    // push coinciding with a pop attempt on an empty queue
    key_data = 4'h6; key_valid = 1'b1;
    repeat (2) @(negedge clk);
    read_port(8'h01, dw);
    n_total++; if (stat_word !== 8'h01) $display("FAIL empty_pp_count: got %h expected %h", stat_word, 8'h01); else n_pass++;
    n_total++; if (data_word !== 8'h86) $display("FAIL empty_pp_head: got %h expected %h", data_word, 8'h86); else n_pass++;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    push_key(4'h7);
    push_key(4'h8);
    port_id = 8'h02; read_strobe = 1'b1;
    #1;
    n_total++; if (stat_word !== 8'h03) $display("FAIL stat_read_word: got %h expected %h", stat_word, 8'h03); else n_pass++;
    @(negedge clk);
    read_strobe = 1'b0; port_id = 8'h00;
    n_total++; if (stat_word !== 8'h03) $display("FAIL stat_no_pop: got %h expected %h", stat_word, 8'h03); else n_pass++;
    n_total++; if (data_word !== 8'h86) $display("FAIL stat_head_kept: got %h expected %h", data_word, 8'h86); else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int k = 1; k <= 4; k++) push_key(4'(k));
    interrupt_ack = 1'b1;
    @(negedge clk);
    interrupt_ack = 1'b0;
    n_total++; if (stat_word !== 8'h04) $display("FAIL mid_count_before: got %h expected %h", stat_word, 8'h04); else n_pass++;
    key_data = 4'hB; key_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    n_total++; if (stat_word !== 8'h00) $display("FAIL mid_rst_count: got %h expected %h", stat_word, 8'h00); else n_pass++;
    n_total++; if ({interrupt, overflow} !== 2'b00) $display("FAIL mid_rst_irq_ovf: got %b expected %b", {interrupt, overflow}, 2'b00); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_total++; if (stat_word !== 8'h00) $display("FAIL mid_no_early_push: got %h expected %h", stat_word, 8'h00); else n_pass++;
    @(negedge clk);
    n_total++; if (data_word !== 8'h8B) $display("FAIL mid_push_after_rst: got %h expected %h", data_word, 8'h8B); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if (stat_word !== 8'h01) $display("FAIL mid_single_push: got %h expected %h", stat_word, 8'h01); else n_pass++;
    n_total++; if (interrupt !== 1'b1) $display("FAIL mid_irq_req: got %b expected %b", interrupt, 1'b1); else n_pass++;
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_first_key();
    test_ack_read();
    test_overflow();
    test_back_to_back_full();
    test_back_to_back_partial();
    test_empty_and_status();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
